// File: rtl/gate_vector_checker_if.sv
// Connection bundle between the gate vector checker and the bench or fabric around it.
// The master side is the checker: it drives the gate inputs and reports status.
interface gate_vector_checker_if #(
    parameter int ERR_W = 3
);
    logic             start;
    logic             dut_y;
    logic             vec_a;
    logic             vec_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic             fail_valid;
    logic [1:0]       fail_idx;

    modport master (
        input  start,
        input  dut_y,
        output vec_a,
        output vec_b,
        output busy,
        output done,
        output pass,
        output err_cnt,
        output fail_valid,
        output fail_idx
    );

    modport slave (
        output start,
        output dut_y,
        input  vec_a,
        input  vec_b,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt,
        input  fail_valid,
        input  fail_idx
    );
endinterface

// File: rtl/gate_vector_checker.sv
// Sweeps the four {a,b} vectors through a 2-input gate, waits SETTLE cycles per vector,
// compares the sampled result with TRUTH and reports error count, first failure and pass.
module gate_vector_checker #(
    parameter logic [3:0] TRUTH  = 4'b1000,
    parameter int         SETTLE = 2,
    parameter int         ERR_W  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    gate_vector_checker_if.master  bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DRIVE  = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // The settle counter is reloaded with SETTLE-1 so DRIVE spans exactly SETTLE cycles.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] val);
        logic [ERR_W-1:0] res;
        if (val == ERR_MAX) begin
            res = val;
        end else begin
            res = val + {{(ERR_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic [1:0]       state_r,      state_s;
    logic [1:0]       idx_r,        idx_s;
    logic [3:0]       cnt_r,        cnt_s;
    logic             vec_a_r,      vec_a_s;
    logic             vec_b_r,      vec_b_s;
    logic             busy_r,       busy_s;
    logic             done_r,       done_s;
    logic             pass_r,       pass_s;
    logic [ERR_W-1:0] err_cnt_r,    err_cnt_s;
    logic             fail_valid_r, fail_valid_s;
    logic [1:0]       fail_idx_r,   fail_idx_s;
    logic             mismatch_s;
    logic [1:0]       idx_inc_s;

    // Next-state and next-output decode for the sweep sequencer.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        cnt_s        = cnt_r;
        vec_a_s      = vec_a_r;
        vec_b_s      = vec_b_r;
        busy_s       = busy_r;
        done_s       = done_r;
        pass_s       = pass_r;
        err_cnt_s    = err_cnt_r;
        fail_valid_s = fail_valid_r;
        fail_idx_s   = fail_idx_r;
        mismatch_s   = (bus.dut_y != TRUTH[idx_r]);
        idx_inc_s    = idx_r + 2'd1;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_s      = ST_DRIVE;
                    idx_s        = 2'd0;
                    cnt_s        = CNT_LOAD;
                    vec_a_s      = 1'b0;
                    vec_b_s      = 1'b0;
                    busy_s       = 1'b1;
                    done_s       = 1'b0;
                    pass_s       = 1'b0;
                    err_cnt_s    = {ERR_W{1'b0}};
                    fail_valid_s = 1'b0;
                    fail_idx_s   = 2'd0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DRIVE: begin
                if (cnt_r == 4'd0) begin
                    state_s = ST_SAMPLE;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (mismatch_s) begin
                    err_cnt_s = sat_inc(err_cnt_r);
                    if (!fail_valid_r) begin
                        fail_valid_s = 1'b1;
                        fail_idx_s   = idx_r;
                    end else begin
                        fail_idx_s   = fail_idx_r;
                    end
                end else begin
                    err_cnt_s = err_cnt_r;
                end
                // The last vector closes the sweep; pass must see this cycle's compare.
                if (idx_r != 2'd3) begin
                    state_s = ST_DRIVE;
                    idx_s   = idx_inc_s;
                    cnt_s   = CNT_LOAD;
                    vec_a_s = idx_inc_s[1];
                    vec_b_s = idx_inc_s[0];
                end else begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_cnt_s == {ERR_W{1'b0}});
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= 2'd0;
            cnt_r        <= 4'd0;
            vec_a_r      <= 1'b0;
            vec_b_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            err_cnt_r    <= {ERR_W{1'b0}};
            fail_valid_r <= 1'b0;
            fail_idx_r   <= 2'd0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            cnt_r        <= cnt_s;
            vec_a_r      <= vec_a_s;
            vec_b_r      <= vec_b_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            pass_r       <= pass_s;
            err_cnt_r    <= err_cnt_s;
            fail_valid_r <= fail_valid_s;
            fail_idx_r   <= fail_idx_s;
        end
    end

    assign bus.vec_a      = vec_a_r;
    assign bus.vec_b      = vec_b_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.pass       = pass_r;
    assign bus.err_cnt    = err_cnt_r;
    assign bus.fail_valid = fail_valid_r;
    assign bus.fail_idx   = fail_idx_r;
endmodule
